mc_cu: RTL and testbench

- Multicycle control unit: sequences a shared-ALU / shared-memory MIPS datapath through the IF, ID, EXE, MEM and WB states.
- Supports the same instruction set as the single-cycle decoder, with identical aluc/pcsource encodings.
- Adds a memory request/ready handshake so instruction and data memory may insert wait states.
- Sits between the instruction register (op/func fields), the ALU zero flag, the memory port and the register file / PC write enables.

---
 rtl/mc_cu.sv | 180 ++++++++++++++++++
 tb/tb_mc_cu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// mc_cu: multicycle MIPS control unit sequencing IF/ID/EXE/MEM/WB with a memory ready handshake.
// Optional illegal-instruction trap to a HALT state is enabled by defining MC_CU_ILLEGAL_TRAP_EN.
module mc_cu #(
  parameter int MEM_HS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       iord,
  output logic       wmem,
  output logic       wir,
  output logic       wpc,
  output logic       waluout,
  output logic       wmdr,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       aluimm,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t st;
  logic   rdy;

  assign rdy   = (MEM_HS == 0) ? 1'b1 : mem_rdy;
  assign state = st;

  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_hamdis;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic i_legal;

  assign r_type   = (op == 6'b000000);
  assign i_add    = r_type & (func == 6'b100000);
  assign i_sub    = r_type & (func == 6'b100010);
  assign i_and    = r_type & (func == 6'b100100);
  assign i_or     = r_type & (func == 6'b100101);
  assign i_xor    = r_type & (func == 6'b100110);
  assign i_sll    = r_type & (func == 6'b000000);
  assign i_srl    = r_type & (func == 6'b000010);
  assign i_sra    = r_type & (func == 6'b000011);
  assign i_jr     = r_type & (func == 6'b001000);
  assign i_hamdis = r_type & (func == 6'b100111);
  assign i_addi   = (op == 6'b001000);
  assign i_andi   = (op == 6'b001100);
  assign i_ori    = (op == 6'b001101);
  assign i_xori   = (op == 6'b001110);
  assign i_lw     = (op == 6'b100011);
  assign i_sw     = (op == 6'b101011);
  assign i_beq    = (op == 6'b000100);
  assign i_bne    = (op == 6'b000101);
  assign i_lui    = (op == 6'b001111);
  assign i_j      = (op == 6'b000010);
  assign i_jal    = (op == 6'b000011);

  assign i_legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                   i_hamdis | i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq |
                   i_bne | i_lui | i_j | i_jal;

  // aluc built bitwise so each bit is the OR of the opcodes that set it
  assign aluc[3] = i_sra | i_hamdis;
  assign aluc[2] = i_sub | i_or | i_srl | i_sra | i_ori | i_beq | i_bne | i_lui;
  assign aluc[1] = i_xor | i_sll | i_srl | i_sra | i_xori | i_lui | i_hamdis;
  assign aluc[0] = i_and | i_or | i_sll | i_srl | i_sra | i_andi | i_ori | i_hamdis;

  assign shift  = i_sll | i_srl | i_sra;
  assign aluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
  assign sext   = i_addi | i_lw | i_sw | i_beq | i_bne;
  assign regrt  = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
  assign m2reg  = i_lw;
  assign jal    = i_jal;

  always_ff @(posedge clock) begin
    if (reset) begin
      st <= S_IF;
    end else begin
      case (st)
        S_IF:  if (rdy) st <= S_ID;
        S_ID: begin
          if (i_j | i_jal | i_jr) st <= S_IF;
          else if (i_legal)       st <= S_EXE;
          else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
            st <= S_HALT;
`else
            st <= S_IF;
`endif
          end
        end
        S_EXE: begin
          if (i_beq | i_bne)    st <= S_IF;
          else if (i_lw | i_sw) st <= S_MEM;
          else                  st <= S_WB;
        end
        S_MEM:   if (rdy) st <= i_lw ? S_WB : S_IF;
        S_WB:    st <= S_IF;
        S_HALT:  st <= S_HALT;
        default: st <= S_IF;
      endcase
    end
  end

`ifdef MC_CU_ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset)                       illegal <= 1'b0;
    else if (st == S_ID && !i_legal) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Strobes are gated by reset so an in-flight access is dropped within the reset cycle.
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    wmem     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    waluout  = 1'b0;
    wmdr     = 1'b0;
    wreg     = 1'b0;
    pcsource = '0;
    if (!reset) begin
      case (st)
        S_IF: begin
          mem_req = 1'b1;
          if (rdy) begin
            wir = 1'b1;
            wpc = 1'b1;
          end
        end
        S_ID: begin
          if (i_j | i_jal) begin
            wpc      = 1'b1;
            pcsource = 2'b11;
            wreg     = i_jal;
          end else if (i_jr) begin
            wpc      = 1'b1;
            pcsource = 2'b10;
          end
        end
        S_EXE: begin
          waluout = 1'b1;
          if ((i_beq & z) | (i_bne & ~z)) begin
            wpc      = 1'b1;
            pcsource = 2'b01;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          wmem    = i_sw;
          wmdr    = i_lw & rdy;
        end
        S_WB:    wreg = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: directed scenarios plus random instruction streams
// compared against a per-instruction expected-trace model.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       z, mem_rdy;
  logic       mem_req, iord, wmem, wir, wpc, waluout, wmdr, wreg;
  logic       regrt, m2reg, jal, shift, aluimm, sext;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;
  logic       illegal;

  mc_cu #(.MEM_HS(1)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc),
    .waluout(waluout), .wmdr(wmdr), .wreg(wreg), .regrt(regrt), .m2reg(m2reg),
    .jal(jal), .shift(shift), .aluimm(aluimm), .sext(sext), .aluc(aluc),
    .pcsource(pcsource), .state(state), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef enum logic [2:0] {T_IF = 3'd0, T_ID = 3'd1, T_EXE = 3'd2, T_MEM = 3'd3,
                            T_WB = 3'd4, T_HALT = 3'd5} tstate_t;
  typedef enum {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL} cls_t;
  // sel = {regrt, m2reg, jal, shift, aluimm, sext}
  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    cls_t       cls;
    logic [3:0] aluc;
    logic [5:0] sel;
  } ins_t;

  ins_t tbl [23];
  int   checks = 0;
  int   errors = 0;
  logic ill_exp = 1'b0;

  // strobe vector b = {mem_req, iord, wmem, wir, wpc, waluout, wmdr, wreg}
  function automatic logic [13:0] ev(input tstate_t s, input logic [7:0] b, input logic [1:0] pcs);
    return {s, b, pcs, ill_exp};
  endfunction

  function automatic logic [13:0] obs();
    return {state, mem_req, iord, wmem, wir, wpc, waluout, wmdr, wreg, pcsource, illegal};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1));
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic [13:0] e, input string tag);
    mem_rdy = r;
    #1;
    chk(tag, {2'b00, obs()}, {2'b00, e});
    @(negedge clock);
  endtask

  task automatic run_ins(input int idx, input int if_wait, input int mem_wait, input logic zin);
    ins_t t;
    logic br;
    t = tbl[idx];
    op = t.op;
    func = (t.op == 6'd0) ? t.func : 6'($urandom);
    z = zin;
    for (int k = 0; k < if_wait; k++) step(1'b0, ev(T_IF, 8'b1000_0000, 2'b00), $sformatf("i%0d_ifwait", idx));
    step(1'b1, ev(T_IF, 8'b1001_1000, 2'b00), $sformatf("i%0d_fetch", idx));
    if (t.cls != C_ILL) begin
      #1;
      chk($sformatf("i%0d_decode", idx), {6'b0, aluc, regrt, m2reg, jal, shift, aluimm, sext},
          {6'b0, t.aluc, t.sel});
    end
    case (t.cls)
      C_J:     begin step(rnd(), ev(T_ID, 8'b0000_1000, 2'b11), $sformatf("i%0d_id", idx)); return; end
      C_JAL:   begin step(rnd(), ev(T_ID, 8'b0000_1001, 2'b11), $sformatf("i%0d_id", idx)); return; end
      C_JR:    begin step(rnd(), ev(T_ID, 8'b0000_1000, 2'b10), $sformatf("i%0d_id", idx)); return; end
      C_ILL:   begin step(rnd(), ev(T_ID, 8'b0, 2'b00), $sformatf("i%0d_id", idx)); return; end
      default: step(rnd(), ev(T_ID, 8'b0, 2'b00), $sformatf("i%0d_id", idx));
    endcase
    if (t.cls == C_BEQ || t.cls == C_BNE) begin
      br = (t.cls == C_BEQ) ? zin : ~zin;
      step(rnd(), ev(T_EXE, {4'b0000, br, 3'b100}, br ? 2'b01 : 2'b00), $sformatf("i%0d_exe", idx));
      return;
    end
    step(rnd(), ev(T_EXE, 8'b0000_0100, 2'b00), $sformatf("i%0d_exe", idx));
    if (t.cls == C_LW || t.cls == C_SW) begin
      for (int k = 0; k < mem_wait; k++)
        step(1'b0, ev(T_MEM, {2'b11, t.cls == C_SW, 5'b0}, 2'b00), $sformatf("i%0d_memwait", idx));
      step(1'b1, ev(T_MEM, {2'b11, t.cls == C_SW, 3'b000, t.cls == C_LW, 1'b0}, 2'b00),
           $sformatf("i%0d_mem", idx));
      if (t.cls == C_SW) return;
    end
    step(rnd(), ev(T_WB, 8'b0000_0001, 2'b00), $sformatf("i%0d_wb", idx));
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 6'b100000, C_ALU, 4'b0000, 6'b000000}; // add
    tbl[1]  = '{6'b000000, 6'b100010, C_ALU, 4'b0100, 6'b000000}; // sub
    tbl[2]  = '{6'b000000, 6'b100100, C_ALU, 4'b0001, 6'b000000}; // and
    tbl[3]  = '{6'b000000, 6'b100101, C_ALU, 4'b0101, 6'b000000}; // or
    tbl[4]  = '{6'b000000, 6'b100110, C_ALU, 4'b0010, 6'b000000}; // xor
    tbl[5]  = '{6'b000000, 6'b000000, C_ALU, 4'b0011, 6'b000100}; // sll / nop
    tbl[6]  = '{6'b000000, 6'b000010, C_ALU, 4'b0111, 6'b000100}; // srl
    tbl[7]  = '{6'b000000, 6'b000011, C_ALU, 4'b1111, 6'b000100}; // sra
    tbl[8]  = '{6'b000000, 6'b100111, C_ALU, 4'b1011, 6'b000000}; // hamdis
    tbl[9]  = '{6'b000000, 6'b001000, C_JR,  4'b0000, 6'b000000}; // jr
    tbl[10] = '{6'b001000, 6'b000000, C_ALU, 4'b0000, 6'b100011}; // addi
    tbl[11] = '{6'b001100, 6'b000000, C_ALU, 4'b0001, 6'b100010}; // andi
    tbl[12] = '{6'b001101, 6'b000000, C_ALU, 4'b0101, 6'b100010}; // ori
    tbl[13] = '{6'b001110, 6'b000000, C_ALU, 4'b0010, 6'b100010}; // xori
    tbl[14] = '{6'b001111, 6'b000000, C_ALU, 4'b0110, 6'b100010}; // lui
    tbl[15] = '{6'b100011, 6'b000000, C_LW,  4'b0000, 6'b110011}; // lw
    tbl[16] = '{6'b101011, 6'b000000, C_SW,  4'b0000, 6'b000011}; // sw
    tbl[17] = '{6'b000100, 6'b000000, C_BEQ, 4'b0100, 6'b000001}; // beq
    tbl[18] = '{6'b000101, 6'b000000, C_BNE, 4'b0100, 6'b000001}; // bne
    tbl[19] = '{6'b000010, 6'b000000, C_J,   4'b0000, 6'b000000}; // j
    tbl[20] = '{6'b000011, 6'b000000, C_JAL, 4'b0000, 6'b001000}; // jal
    tbl[21] = '{6'b111111, 6'b000000, C_ILL, 4'b0000, 6'b000000}; // unknown op
    tbl[22] = '{6'b000000, 6'b111111, C_ILL, 4'b0000, 6'b000000}; // unknown R func

    reset = 1'b1; mem_rdy = 1'b0; op = '0; func = '0; z = 1'b0;
    @(negedge clock);
    step(1'b1, ev(T_IF, 8'b0, 2'b00), "reset_state");
    reset = 1'b0;

    run_ins(0, 0, 0, 1'b0);   // add
    run_ins(15, 0, 2, 1'b0);  // lw with two MEM wait cycles
    run_ins(17, 0, 0, 1'b1);  // beq taken
    run_ins(17, 0, 0, 1'b0);  // beq not taken
    run_ins(18, 1, 0, 1'b0);  // bne taken, IF wait
    run_ins(20, 0, 0, 1'b0);  // jal
    run_ins(5, 0, 0, 1'b0);   // nop as sll

    // sw interrupted by reset while MEM is waiting
    op = 6'b101011; func = '0; z = 1'b0;
    step(1'b1, ev(T_IF, 8'b1001_1000, 2'b00), "swrst_fetch");
    step(rnd(), ev(T_ID, 8'b0, 2'b00), "swrst_id");
    step(rnd(), ev(T_EXE, 8'b0000_0100, 2'b00), "swrst_exe");
    step(1'b0, ev(T_MEM, 8'b1110_0000, 2'b00), "swrst_memwait");
    reset = 1'b1;
    step(1'b0, ev(T_MEM, 8'b0, 2'b00), "swrst_during");
    step(1'b0, ev(T_IF, 8'b0, 2'b00), "swrst_after");
    reset = 1'b0;

    for (int n = 0; n < 200; n++)
      run_ins(int'($urandom_range(20)), int'($urandom_range(2)), int'($urandom_range(3)), rnd());

`ifdef MC_CU_ILLEGAL_TRAP_EN
    op = 6'b111111; func = 6'($urandom);
    step(1'b1, ev(T_IF, 8'b1001_1000, 2'b00), "ill_fetch");
    step(rnd(), ev(T_ID, 8'b0, 2'b00), "ill_id");
    ill_exp = 1'b1;
    for (int k = 0; k < 10; k++) step(rnd(), ev(T_HALT, 8'b0, 2'b00), "ill_halt");
    reset = 1'b1;
    step(rnd(), ev(T_HALT, 8'b0, 2'b00), "ill_reset_cycle");
    ill_exp = 1'b0;
    step(rnd(), ev(T_IF, 8'b0, 2'b00), "ill_cleared");
    reset = 1'b0;
    run_ins(0, 0, 0, 1'b0);
`else
    run_ins(21, 0, 0, 1'b0);
    run_ins(22, 1, 0, 1'b0);
    run_ins(0, 0, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
